// File: rtl/coproc_clk_pkg.sv
// Shared types and defaults for the coprocessor clock-enable sequencer.
// Contents: mode encoding (identical to cfg_mode), default widths, reset
// divisor and the minimum divisor that cfg_div is clamped to.
package coproc_clk_pkg;

  localparam int unsigned DEF_CNT_W     = 28;
  localparam int unsigned DEF_BURST_W   = 8;
  localparam int unsigned DEF_DIV_RESET = 10;
  localparam int unsigned MIN_DIV       = 2;

  typedef enum logic [1:0] {
    MODE_STOP  = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_BURST = 2'd2,
    MODE_STEP  = 2'd3
  } mode_e;

endpackage

// File: rtl/clock_sequencer_if.sv
// Configuration / status bundle of the clock sequencer.
// master: configuration source (drives cfg_*, abort, step_in).
// slave : the sequencer (drives cfg_ready, tick_en, clock_out, busy, done, mode_o).
interface clock_sequencer_if #(
  parameter int unsigned CNT_W   = coproc_clk_pkg::DEF_CNT_W,
  parameter int unsigned BURST_W = coproc_clk_pkg::DEF_BURST_W
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_mode;
  logic [CNT_W-1:0]   cfg_div;
  logic [BURST_W-1:0] cfg_count;
  logic               abort;
  logic               step_in;
  logic               tick_en;
  logic               clock_out;
  logic               busy;
  logic               done;
  logic [1:0]         mode_o;

  modport master (
    output cfg_valid, cfg_mode, cfg_div, cfg_count, abort, step_in,
    input  cfg_ready, tick_en, clock_out, busy, done, mode_o
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_div, cfg_count, abort, step_in,
    output cfg_ready, tick_en, clock_out, busy, done, mode_o
  );

endinterface

// File: rtl/step_edge_detect.sv
// Rising-edge detector for the single-step push-button.
// Ports: clock_in, reset_n (async, active-low), step_in (button),
//        rise_c (combinational one-cycle pulse on a sampled rising edge).
// Macro CLOCK_SEQUENCER_STEP_SYNC_EN: when defined, step_in first passes a
// 2-flop synchronizer (asynchronous board button); otherwise it is taken as
// synchronous to clock_in.
module step_edge_detect (
  input  logic clock_in,
  input  logic reset_n,
  input  logic step_in,
  output logic rise_c
);

  logic sample_c;
  logic prev_q;

`ifdef CLOCK_SEQUENCER_STEP_SYNC_EN
  logic [1:0] sync_q;

  // Two-stage synchronizer for the asynchronous button
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], step_in};
    end
  end

  assign sample_c = sync_q[1];
`else
  assign sample_c = step_in;
`endif

  // Previous sample for edge detection
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sample_c;
    end
  end

  assign rise_c = sample_c & ~prev_q;

endmodule

// File: rtl/clock_sequencer.sv
// Programmable clock-enable sequencer for the arithmetic coprocessor.
// Modes: STOP, RUN (free-running at div), BURST (cfg_count ticks), STEP
// (one tick per button press). tick_en is the datapath advance strobe;
// clock_out is a 50 %-duty view of the period for LEDs/debug.
// Ports: clock_in, reset_n (async, active-low), seq (clock_sequencer_if.slave).
// Macro CLOCK_SEQUENCER_STEP_SYNC_EN: synchronize step_in (see step_edge_detect).
module clock_sequencer
  import coproc_clk_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned BURST_W   = DEF_BURST_W,
  parameter int unsigned DIV_RESET = DEF_DIV_RESET
) (
  input  logic             clock_in,
  input  logic             reset_n,
  clock_sequencer_if.slave seq
);

  mode_e              state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               tick_q, tick_d;
  logic               clk_q, clk_d;
  logic               done_q, done_d;

  logic               step_rise_c;
  logic               accept_c;
  logic               wrap_c;
  logic               half_c;
  logic [CNT_W-1:0]   cnt_next_c;
  logic [CNT_W-1:0]   div_clamped_c;

  step_edge_detect u_step_edge (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .step_in  (seq.step_in),
    .rise_c   (step_rise_c)
  );

  assign accept_c      = seq.cfg_valid && (state_q != MODE_BURST);
  assign wrap_c        = (cnt_q == (div_q - CNT_W'(1)));
  assign half_c        = (cnt_q < (div_q >> 1));
  assign cnt_next_c    = wrap_c ? '0 : (cnt_q + CNT_W'(1));
  assign div_clamped_c = (seq.cfg_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : seq.cfg_div;

  // State and datapath registers
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MODE_STOP;
      cnt_q   <= '0;
      div_q   <= CNT_W'(DIV_RESET);
      rem_q   <= '0;
      tick_q  <= 1'b0;
      clk_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      tick_q  <= tick_d;
      clk_q   <= clk_d;
      done_q  <= done_d;
    end
  end

  // Next-state and registered-output logic; abort beats accept beats step
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    rem_d   = rem_q;
    tick_d  = 1'b0;
    clk_d   = 1'b0;
    done_d  = 1'b0;

    if (seq.abort) begin
      state_d = MODE_STOP;
      cnt_d   = '0;
    end else if (accept_c) begin
      // Accepting restarts the period; a zero-length burst signals done at once
      state_d = mode_e'(seq.cfg_mode);
      div_d   = div_clamped_c;
      rem_d   = seq.cfg_count;
      cnt_d   = '0;
      done_d  = (mode_e'(seq.cfg_mode) == MODE_BURST) && (seq.cfg_count == '0);
    end else begin
      case (state_q)
        MODE_RUN: begin
          cnt_d  = cnt_next_c;
          tick_d = wrap_c;
          clk_d  = half_c;
        end
        MODE_BURST: begin
          if (done_q) begin
            state_d = MODE_STOP;
            cnt_d   = '0;
          end else if (rem_q != '0) begin
            cnt_d = cnt_next_c;
            clk_d = half_c;
            if (wrap_c) begin
              tick_d = 1'b1;
              rem_d  = rem_q - BURST_W'(1);
            end
          end else if (tick_q) begin
            // Final tick is on the outputs now; flag completion next cycle
            done_d = 1'b1;
            cnt_d  = '0;
          end
        end
        MODE_STEP: begin
          cnt_d  = '0;
          tick_d = step_rise_c;
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

  assign seq.cfg_ready = (state_q != MODE_BURST);
  assign seq.tick_en   = tick_q;
  assign seq.clock_out = clk_q;
  assign seq.busy      = (state_q == MODE_RUN) || (state_q == MODE_BURST);
  assign seq.done      = done_q;
  assign seq.mode_o    = state_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// Scoreboard bench for clock_sequencer: stimulus pushes expected tick/done
// events (cycle-stamped) into a queue; a monitor pops and compares each one
// the DUT produces. Status outputs are checked directly.
module tb_clock_sequencer;

  localparam int CNT_W   = 28;
  localparam int BURST_W = 8;

`ifdef CLOCK_SEQUENCER_STEP_SYNC_EN
  localparam int STEP_LAT = 3;
`else
  localparam int STEP_LAT = 1;
`endif

  typedef struct {
    bit is_done;
    int cycle;
  } ev_t;

  logic clock_in;
  logic reset_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  sb[$];

  clock_sequencer_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) seq ();

  clock_sequencer #(
    .CNT_W     (CNT_W),
    .BURST_W   (BURST_W),
    .DIV_RESET (10)
  ) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .seq      (seq)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  always @(posedge clock_in) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic void expect_ev(input bit is_done, input int cycle);
    ev_t e;
    e.is_done = is_done;
    e.cycle   = cycle;
    sb.push_back(e);
  endfunction

  function automatic void sb_check(input bit is_done);
    ev_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL sb_unexpected_%s: got event at cycle %0d, required none",
               is_done ? "done" : "tick", cyc);
    end else begin
      e = sb.pop_front();
      if (e.is_done != is_done || e.cycle != cyc) begin
        miscompares++;
        $display("FAIL sb_event: got %s at cycle %0d, required %s at cycle %0d",
                 is_done ? "done" : "tick", cyc, e.is_done ? "done" : "tick", e.cycle);
      end
    end
  endfunction

  // Monitor: sample away from the active edge
  always @(negedge clock_in) begin
    if (seq.tick_en) sb_check(1'b0);
    if (seq.done)    sb_check(1'b1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock_in);
      #1;
    end
  endtask

  task automatic cfg(input logic [1:0] mode, input int div, input int count, output int e);
    seq.cfg_valid = 1'b1;
    seq.cfg_mode  = mode;
    seq.cfg_div   = CNT_W'(div);
    seq.cfg_count = BURST_W'(count);
    step(1);
    e = cyc;
    seq.cfg_valid = 1'b0;
  endtask

  task automatic press(input int len, input int gap);
    seq.step_in = 1'b1;
    expect_ev(1'b0, cyc + STEP_LAT);
    step(len);
    seq.step_in = 1'b0;
    step(gap);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tick"},  int'(seq.tick_en),   0);
    chk({tag, "_clk"},   int'(seq.clock_out), 0);
    chk({tag, "_busy"},  int'(seq.busy),      0);
    chk({tag, "_done"},  int'(seq.done),      0);
    chk({tag, "_mode"},  int'(seq.mode_o),    0);
    chk({tag, "_ready"}, int'(seq.cfg_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int e;
    int clk_pat[8] = '{1, 1, 0, 0, 1, 1, 0, 0};

    reset_n       = 1'b0;
    seq.cfg_valid = 1'b0;
    seq.cfg_mode  = 2'd0;
    seq.cfg_div   = '0;
    seq.cfg_count = '0;
    seq.abort     = 1'b0;
    seq.step_in   = 1'b0;

    step(2);
    chk_reset_outputs("por");
    reset_n = 1'b1;
    step(2);

    // RUN div=4: ticks every 4, clock_out 1,1,0,0
    cfg(2'd1, 4, 0, e);
    expect_ev(1'b0, e + 4);
    expect_ev(1'b0, e + 8);
    expect_ev(1'b0, e + 12);
    chk("run_mode", int'(seq.mode_o), 1);
    chk("run_busy", int'(seq.busy), 1);
    for (int j = 0; j < 8; j++) begin
      step(1);
      chk($sformatf("run_clk%0d", j + 1), int'(seq.clock_out), clk_pat[j]);
    end
    step(4);

    // RUN reconfiguration restarts the period (div=3)
    cfg(2'd1, 3, 0, e);
    expect_ev(1'b0, e + 3);
    expect_ev(1'b0, e + 6);
    step(7);

    // Reset mid-RUN: outputs clear immediately, no tick afterwards
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    step(2);
    reset_n = 1'b1;
    step(12);
    chk("rst_after_mode", int'(seq.mode_o), 0);

    // BURST div=2 count=3
    cfg(2'd2, 2, 3, e);
    expect_ev(1'b0, e + 2);
    expect_ev(1'b0, e + 4);
    expect_ev(1'b0, e + 6);
    expect_ev(1'b1, e + 7);
    chk("burst_ready0", int'(seq.cfg_ready), 0);
    chk("burst_busy",   int'(seq.busy), 1);
    chk("burst_mode",   int'(seq.mode_o), 2);
    step(3);
    chk("burst_ready3", int'(seq.cfg_ready), 0);
    step(3);
    chk("burst_ready6", int'(seq.cfg_ready), 0);
    step(2);
    chk("burst_end_mode",  int'(seq.mode_o), 0);
    chk("burst_end_ready", int'(seq.cfg_ready), 1);
    step(2);

    // BURST count=0: done in the first BURST cycle, no tick
    cfg(2'd2, 5, 0, e);
    expect_ev(1'b1, e);
    chk("b0_mode", int'(seq.mode_o), 2);
    step(1);
    chk("b0_end_mode", int'(seq.mode_o), 0);
    step(6);

    // BURST cfg_div=1 behaves as div=2
    cfg(2'd2, 1, 2, e);
    expect_ev(1'b0, e + 2);
    expect_ev(1'b0, e + 4);
    expect_ev(1'b1, e + 5);
    step(7);
    chk("bdiv1_end_mode", int'(seq.mode_o), 0);

    // BURST of 5 aborted after the first tick: STOP, no done
    cfg(2'd2, 3, 5, e);
    expect_ev(1'b0, e + 3);
    step(3);
    seq.abort = 1'b1;
    step(1);
    seq.abort = 1'b0;
    chk("abort_mode", int'(seq.mode_o), 0);
    chk("abort_busy", int'(seq.busy), 0);
    step(12);

    // Abort beats a configuration in the same cycle
    seq.abort = 1'b1;
    cfg(2'd1, 2, 0, e);
    seq.abort = 1'b0;
    chk("abort_cfg_mode", int'(seq.mode_o), 0);
    step(8);

    // STEP: three short presses plus one held for 20 cycles
    cfg(2'd3, 4, 0, e);
    chk("step_mode", int'(seq.mode_o), 3);
    chk("step_busy", int'(seq.busy), 0);
    step(2);
    press(2, 5);
    press(1, 5);
    press(3, 5);
    press(20, 6);
    chk("step_clk", int'(seq.clock_out), 0);

    // Step edge coinciding with an accepted RUN config is discarded
    seq.step_in = 1'b1;
    cfg(2'd1, 4, 0, e);
    expect_ev(1'b0, e + 4);
    expect_ev(1'b0, e + 8);
    step(9);
    seq.step_in = 1'b0;
    cfg(2'd0, 4, 0, e);
    step(6);
    chk("final_mode", int'(seq.mode_o), 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_sequencer.md
# clock_sequencer

Programmable clock-enable sequencer for the arithmetic coprocessor datapath. It replaces the fixed-divisor clock divider with a runtime-configurable controller: stopped, free-running at a programmable divisor, fixed-length bursts, or single-step from a push-button. It emits a one-cycle `tick_en` strobe that the coprocessor datapath uses as its advance enable. It also emits a 50 %-duty `clock_out` for LED or debug visibility.

## Interface
- `CNT_W`, 28: width of the period counter and divisor.
- `BURST_W`, 8: width of the burst length.
- `DIV_RESET`, 10: divisor loaded at reset.
- `clock_in` in 1: the single clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: a configuration request is present.
- `cfg_ready` out 1: the block can accept a configuration; equals `state != BURST`.
- `cfg_mode` in 2: requested mode: 0 STOP, 1 RUN, 2 BURST, 3 STEP.
- `cfg_div` in CNT_W: tick period in `clock_in` cycles; values below 2 are clamped to 2.
- `cfg_count` in BURST_W: number of ticks for a BURST.
- `abort` in 1: forces STOP.
- `step_in` in 1: step button, active-high.
- `tick_en` out 1: one-cycle datapath enable strobe.
- `clock_out` out 1: square-wave view of the period.
- `busy` out 1: high in RUN or BURST.
- `done` out 1: one-cycle pulse when a BURST completes.
- `mode_o` out 2: current state encoding.

## Operation
- Four states (STOP, RUN, BURST, STEP); the encoding is identical to `cfg_mode`.
- **Accept:** a configuration is accepted on a rising edge where `cfg_valid & cfg_ready`. On acceptance:
  - `div` is loaded with `max(cfg_div, 2)`.
  - `remaining` is loaded with `cfg_count`.
  - `cnt` is cleared to 0.
  - The state changes to `cfg_mode` on the next cycle.
- **Period counter:** in RUN and BURST, `cnt` counts 0 to div-1 and wraps to 0.
  - `tick_en` = (`cnt` == div-1) in RUN, or in BURST while `remaining` != 0.
  - `clock_out` = (`cnt` < div/2), using integer division.
- **STOP and STEP:** `cnt` is held at 0, and `clock_out` is held at 0.
- **BURST:** each tick decrements `remaining`.
  - When the tick that brings `remaining` to 0 fires, the next cycle pulses `done` and the state goes to STOP.
  - If `cfg_count` = 0, there is no tick: `done` pulses in the first BURST cycle, then the state goes to STOP.
- **STEP:** each rising edge of `step_in` produces exactly one `tick_en` pulse. A held button produces no further ticks.
- **RUN reconfiguration:** a configuration accepted in RUN restarts the period, because `cnt` is cleared to 0.
- **Abort:** `abort` forces STOP on the next edge from any state. It has priority over a configuration accepted in the same cycle. An aborted BURST does not pulse `done`.
- **Simultaneous events:**
  - An accepted configuration has priority over a `step_in` edge in the same cycle; that edge is discarded.
  - An edge seen outside STEP is discarded.
- **Reset values:**
  - state STOP, `div` = DIV_RESET, `cnt` = 0, `remaining` = 0.
  - `tick_en`, `clock_out`, `busy` and `done` are 0.
  - `mode_o` = 0, `cfg_ready` = 1.
- **Reset mid-operation:** a reset during any state returns to the values above immediately; there is no pending tick after release.

## Timing
- RUN and BURST: with a configuration accepted on edge k, the first `tick_en` occurs in cycle k+div, then every div cycles.
- `clock_out` is high for div/2 cycles and low for div − div/2 cycles of each period.
- STEP, without the macro: `tick_en` is high in the cycle after the first edge on which `step_in` is sampled high. This is 1 cycle of latency.
- `done` comes 1 cycle after the final burst tick.
- `busy` and `mode_o` update on the cycle the state changes.

## Configuration
- `CLOCK_SEQUENCER_STEP_SYNC_EN`:
  - **Defined:** `step_in` passes through a 2-flop synchronizer before edge detection, so step-to-tick latency is 3 cycles. This is for asynchronous board buttons.
  - **Undefined:** `step_in` is treated as synchronous to `clock_in`, with 1-cycle latency.
- All other behaviour is identical with or without the macro.

## Structure
- **Package `coproc_clk_pkg`:**
  - the mode enum (`MODE_STOP`, `MODE_RUN`, `MODE_BURST`, `MODE_STEP`);
  - default `CNT_W`, `BURST_W` and `DIV_RESET` constants;
  - the minimum-divisor constant (2).
- **Sub-module `step_edge_detect`:** contains the optional synchronizer (under the macro), the previous-sample register and the rising-edge output. Uses the same clock and reset.
- The top level holds the FSM, the period counter and the burst counter.

## Test plan
- **Reset:** assert `reset_n` low mid-RUN -> all outputs at reset values; `cfg_ready` = 1; `mode_o` = 0; no `tick_en` after release.
- **RUN, div=4:** configure RUN with `cfg_div` = 4 -> `tick_en` at k+4, k+8, k+12; `clock_out` pattern 1,1,0,0 repeating.
- **BURST, div=2, count=3:**
  - exactly 3 ticks, 2 cycles apart;
  - `done` one cycle after the third tick, then STOP;
  - `cfg_ready` = 0 throughout the burst.
- **Burst edge cases:**
  - count = 0 -> `done` pulse and no tick;
  - `cfg_div` = 1 -> behaves as div = 2;
  - `abort` after the first of 5 ticks -> STOP next cycle, no `done`.
- **STEP:** 3 separated button presses plus one press held for 20 cycles -> exactly 4 ticks, each 1 cycle after its edge (3 cycles with the macro).
- **Simultaneous events:** `step_in` edge in the same cycle as an accepted RUN configuration -> no step tick; RUN starts normally.
